// File: rtl/add_core_pkg.sv
// add_core_pkg: shared defaults and width helpers for the add_core block.
//   ADD_WIDTH_DEF  - default operand width
//   FIFO_DEPTH_DEF - default result-buffer depth (power of two)
//   LEVEL_W_DEF    - width of the level output for the default depth
//   OPS_W          - width of the delivered-results counter
//   sum_width()    - result width (operand width plus carry-out)
//   level_width()  - occupancy width able to represent 0..depth
package add_core_pkg;

  localparam int ADD_WIDTH_DEF  = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LEVEL_W_DEF    = $clog2(FIFO_DEPTH_DEF) + 1;
  localparam int OPS_W          = 16;

  function automatic int sum_width(input int add_width);
    return add_width + 1;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/add_core_fifo.sv
// add_core_fifo: circular result buffer with wrapping read/write pointers.
//   clk, rst       - clock, asynchronous active-low reset
//   push_i         - write push_data_i at the tail
//   pop_i          - consume the head entry (ignored while empty)
//   pop_data_o     - head entry, zero while empty
//   full_o/empty_o - occupancy flags
//   level_o        - number of entries held
// A push while full is only honoured together with a pop, so an entry is
// never overwritten.
module add_core_fifo
  import add_core_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   LVL_ZERO  = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]   LVL_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   LVL_FULL  = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q,  level_d;
  logic             do_push_s, do_pop_s;

  // Flags, handshake qualification, pointer and level next-state.
  always_comb begin
    empty_o   = (level_q == LVL_ZERO);
    full_o    = (level_q == LVL_FULL);
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (do_push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_ONE);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Head presentation; an empty buffer shows zero rather than stale data.
  always_comb begin
    if (empty_o) begin
      pop_data_o = {WIDTH{1'b0}};
    end else begin
      pop_data_o = mem_q[rd_ptr_q];
    end
    level_o = level_q;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      level_q  <= LVL_ZERO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are only observable through a non-zero level,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/add_core.sv
// add_core: two-stage adder feeding a credit-controlled result buffer.
//   clk, rst            - clock, asynchronous active-low reset
//   in_valid/in_ready/a/b - operand-pair handshake
//   sum_valid/sum_ready/sum - result handshake; sum MSB is the carry-out
//   level               - results held in the buffer
//   ops_done            - results delivered, wraps at 16 bits
// S1 registers the accepted pair; the sum of the S1 registers is written
// into the buffer on the following edge, so a pair accepted at edge t is
// at the buffer head after t+1 and can be delivered at edge t+2.
module add_core
  import add_core_pkg::*;
#(
  parameter int ADD_WIDTH  = ADD_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ADD_WIDTH-1:0]                a,
  input  logic [ADD_WIDTH-1:0]                b,
  output logic                                sum_valid,
  input  logic                                sum_ready,
  output logic [sum_width(ADD_WIDTH)-1:0]     sum,
  output logic [level_width(FIFO_DEPTH)-1:0]  level,
  output logic [OPS_W-1:0]                    ops_done
);

  localparam int SUM_W = sum_width(ADD_WIDTH);
  localparam int LVL_W = level_width(FIFO_DEPTH);
  localparam logic [LVL_W:0]     DEPTH_CNT = (LVL_W+1)'(FIFO_DEPTH);
  localparam logic [OPS_W-1:0]   OPS_ONE   = OPS_W'(1);

  logic                  s1_valid_q, s1_valid_d;
  logic [ADD_WIDTH-1:0]  s1_a_q, s1_a_d;
  logic [ADD_WIDTH-1:0]  s1_b_q, s1_b_d;
  logic [OPS_W-1:0]      ops_done_q, ops_done_d;
  logic [SUM_W-1:0]      s2_sum_s;
  logic [LVL_W:0]        occupancy_s;
  logic                  in_xfer_s, out_xfer_s;
  logic                  fifo_full_s, fifo_empty_s;

  // Credit: buffered results plus the one in S1 must leave room, so every
  // S2 write has a free slot. Only registered state (and reset) feeds it.
  always_comb begin
    occupancy_s = {1'b0, level} + {{LVL_W{1'b0}}, s1_valid_q};
    in_ready    = rst & ~fifo_full_s & (occupancy_s < DEPTH_CNT);
    sum_valid   = ~fifo_empty_s;
    in_xfer_s   = in_valid & in_ready;
    out_xfer_s  = sum_valid & sum_ready;
  end

  // S1 capture, S2 add, and delivered-results counter next-state.
  always_comb begin
    s1_valid_d = in_xfer_s;
    if (in_xfer_s) begin
      s1_a_d = a;
      s1_b_d = b;
    end else begin
      s1_a_d = s1_a_q;
      s1_b_d = s1_b_q;
    end
    s2_sum_s = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    if (out_xfer_s) begin
      ops_done_d = ops_done_q + OPS_ONE;
    end else begin
      ops_done_d = ops_done_q;
    end
  end

  // S1 pipeline registers and ops counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= {ADD_WIDTH{1'b0}};
      s1_b_q     <= {ADD_WIDTH{1'b0}};
      ops_done_q <= {OPS_W{1'b0}};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign ops_done = ops_done_q;

  add_core_fifo #(
    .WIDTH (SUM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (s1_valid_q),
    .push_data_i (s2_sum_s),
    .pop_i       (sum_ready),
    .pop_data_o  (sum),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .level_o     (level)
  );

endmodule
